ov7670_capture: RTL



---
 rtl/ov7670_pkg.sv | 32 +++
 rtl/ov7670_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : ov7670_pkg                                                 |
// | Description : Shared types, constants and the RGB565 -> 4-bit grayscale  |
// |               conversion used by the OV7670 capture path.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package ov7670_pkg;

   // Capture controller states
   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      BLANK     = 2'd1,
      CAPTURE   = 2'd2
   } cap_state_t;

   // Frame buffer address width (covers 640*480 = 307200 locations)
   localparam int ADDR_W = 19;

   // first_byte = {R5, G6[5:3]}, second_byte = {G6[2:0], B5}.
   // Unweighted sum R+G+B (0..125) scaled down to 4 bits by dropping 3 LSBs.
   function automatic logic [3:0] rgb565_to_gray4(input logic [7:0] first_byte,
                                                  input logic [7:0] second_byte);
      logic [6:0] sum;
      sum = 7'(first_byte[7:3])
          + 7'({first_byte[2:0], second_byte[7:5]})
          + 7'(second_byte[4:0]);
      return sum[6:3];
   endfunction

endpackage : ov7670_pkg
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ov7670_capture                                             |
// | Description : Samples the OV7670 parallel bus (RGB565, two bytes per     |
// |               pixel), converts each pixel to 4-bit grayscale and writes  |
// |               it into a raster-ordered frame buffer. Reports frame done, |
// |               line-length error and overflow per frame.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   pclk        in   camera pixel clock, all logic on rising edge          |
// |   rst_n       in   asynchronous active-low reset                         |
// |   cam_vsync   in   frame sync from camera                                |
// |   cam_href    in   line valid from camera                                |
// |   cam_data    in   camera data byte [7:0]                                |
// |   frame_addr  out  frame buffer write address [18:0]                     |
// |   frame_pixel out  grayscale write data [3:0]                            |
// |   frame_we    out  write strobe, one cycle per pixel                     |
// |   frame_done  out  one-cycle pulse at end of a captured frame            |
// |   line_err    out  a line in this frame had a wrong pixel count          |
// |   overflow    out  more than hRez*vRez pixels arrived in this frame      |
// +--------------------------------------------------------------------------+
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int   hRez         = 640,
   parameter int   vRez         = 480,
   parameter logic vsync_active = 1'b1
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   output logic [ADDR_W-1:0] frame_addr,
   output logic [3:0]        frame_pixel,
   output logic              frame_we,
   output logic              frame_done,
   output logic              line_err,
   output logic              overflow
);

   localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(hRez * vRez);
   localparam int                LCNT_W    = $clog2(hRez + 2);
   localparam logic [LCNT_W-1:0] LINE_LEN  = LCNT_W'(hRez);
   // Line counter saturates one past the expected length so long lines
   // can never wrap back onto a "correct" count.
   localparam logic [LCNT_W-1:0] LINE_SAT  = LCNT_W'(hRez + 1);

   // Input register stage
   logic       vs_q, hr_q;
   logic [7:0] d_q;

   // Control / pairing stage
   cap_state_t        state_q,      state_d;
   logic              phase_q,      phase_d;
   logic [7:0]        first_q,      first_d;
   logic              hr_prev_q;
   logic [LCNT_W-1:0] line_cnt_q,   line_cnt_d;
   logic [ADDR_W-1:0] addr_cnt_q,   addr_cnt_d;
   logic              line_err_q,   line_err_d;
   logic              overflow_q,   overflow_d;
   logic              frame_done_q, frame_done_d;
   logic              pix_we_q,     pix_we_d;
   logic [3:0]        pix_q,        pix_d;
   logic [ADDR_W-1:0] pix_addr_q,   pix_addr_d;

   // Output write stage
   logic              frame_we_q,    frame_we_d;
   logic [3:0]        frame_pixel_q, frame_pixel_d;
   logic [ADDR_W-1:0] frame_addr_q,  frame_addr_d;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         // Reset vsync to its inactive level so a fresh blanking interval
         // must be observed before anything is captured.
         vs_q <= ~vsync_active;
         hr_q <= 1'b0;
         d_q  <= 8'h00;
      end else begin
         vs_q <= cam_vsync;
         hr_q <= cam_href;
         d_q  <= cam_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      phase_d      = 1'b0;
      first_d      = first_q;
      line_cnt_d   = line_cnt_q;
      addr_cnt_d   = addr_cnt_q;
      line_err_d   = line_err_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;
      pix_we_d     = 1'b0;
      pix_d        = pix_q;
      pix_addr_d   = pix_addr_q;

      case (state_q)
         WAIT_SYNC: begin
            if (vs_q == vsync_active) state_d = BLANK;
         end
         BLANK: begin
            // Flags survive the frame_done cycle and are cleared here.
            addr_cnt_d = '0;
            line_cnt_d = '0;
            line_err_d = 1'b0;
            overflow_d = 1'b0;
            if (vs_q != vsync_active) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (vs_q == vsync_active) begin
               // Aborts any line in progress: pending byte dropped, no check.
               state_d      = BLANK;
               frame_done_d = 1'b1;
            end else if (hr_q) begin
               if (!hr_prev_q) line_cnt_d = '0;
               if (!phase_q) begin
                  first_d = d_q;
                  phase_d = 1'b1;
               end else begin
                  if (line_cnt_d != LINE_SAT) line_cnt_d = line_cnt_d + LCNT_W'(1);
                  if (addr_cnt_q != PIX_TOTAL) begin
                     pix_we_d   = 1'b1;
                     pix_d      = rgb565_to_gray4(first_q, d_q);
                     pix_addr_d = addr_cnt_q;
                     addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end else if (hr_prev_q && (line_cnt_q != LINE_LEN)) begin
               line_err_d = 1'b1;
            end
         end
         default: state_d = WAIT_SYNC;
      endcase
   end

   always_comb begin
      frame_we_d    = pix_we_q;
      frame_pixel_d = pix_we_q ? pix_q      : frame_pixel_q;
      frame_addr_d  = pix_we_q ? pix_addr_q : frame_addr_q;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= WAIT_SYNC;
         phase_q       <= 1'b0;
         first_q       <= 8'h00;
         hr_prev_q     <= 1'b0;
         line_cnt_q    <= '0;
         addr_cnt_q    <= '0;
         line_err_q    <= 1'b0;
         overflow_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         pix_we_q      <= 1'b0;
         pix_q         <= 4'h0;
         pix_addr_q    <= '0;
         frame_we_q    <= 1'b0;
         frame_pixel_q <= 4'h0;
         frame_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         first_q       <= first_d;
         hr_prev_q     <= hr_q;
         line_cnt_q    <= line_cnt_d;
         addr_cnt_q    <= addr_cnt_d;
         line_err_q    <= line_err_d;
         overflow_q    <= overflow_d;
         frame_done_q  <= frame_done_d;
         pix_we_q      <= pix_we_d;
         pix_q         <= pix_d;
         pix_addr_q    <= pix_addr_d;
         frame_we_q    <= frame_we_d;
         frame_pixel_q <= frame_pixel_d;
         frame_addr_q  <= frame_addr_d;
      end
   end

   assign frame_addr  = frame_addr_q;
   assign frame_pixel = frame_pixel_q;
   assign frame_we    = frame_we_q;
   assign frame_done  = frame_done_q;
   assign line_err    = line_err_q;
   assign overflow    = overflow_q;

endmodule : ov7670_capture
`default_nettype wire
